// File: rtl/bcd_digit_scanner_if.sv
// rtl/bcd_digit_scanner_if.sv - load handshake interface for the BCD digit scanner
//
// Purpose: carries the valid/ready load handshake and the packed BCD value
//          from the producer (master) to the scanner (slave).
// Signals:
//   load_valid  master->slave  load_data is valid
//   load_ready  slave->master  scanner can accept a load
//   load_data   master->slave  BCD value, nibble i at bits [4i+3:4i]
interface bcd_digit_scanner_if #(
    parameter int DIGITS = 4
);
    logic                  load_valid;
    logic                  load_ready;
    logic [4*DIGITS-1:0]   load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/bcd_digit_scanner.sv
// rtl/bcd_digit_scanner.sv - time-multiplexed BCD digit scan controller
//
// Purpose: holds a double-buffered multi-digit BCD value and scans one nibble
//          per slot onto a BCD-to-7-segment decoder, with anti-ghosting blank
//          cycles, invalid-nibble blanking and optional leading-zero blanking.
// Ports:
//   clk                     rising-edge clock
//   rst                     synchronous active-high reset
//   load_if (slave)         load_valid / load_ready / load_data handshake
//   lz_suppress             leading-zero blanking enable, sampled every cycle
//   bcd_w..bcd_z            current nibble (bcd_w = MSB)
//   digit_en                one-hot digit enable, all zero while blanked
//   blank                   high when digit_en is all zero
//   frame_done              one-cycle pulse on the last cycle of the last slot
module bcd_digit_scanner #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_digit_scanner_if.slave   load_if,
    input  logic                 lz_suppress,
    output logic                 bcd_w,
    output logic                 bcd_x,
    output logic                 bcd_y,
    output logic                 bcd_z,
    output logic [DIGITS-1:0]    digit_en,
    output logic                 blank,
    output logic                 frame_done
);
    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW     = 4 * DIGITS;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGITS - 1);

    // Scan and buffer state
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [DW-1:0]      active_q, active_d;
    logic [DW-1:0]      pending_q, pending_d;
    logic               pending_full_q, pending_full_d;

    // Registered pin drivers
    logic [3:0]         bcd_q, bcd_d;
    logic [DIGITS-1:0]  digit_en_q, digit_en_d;
    logic               blank_q, blank_d;
    logic               frame_done_q, frame_done_d;

    logic               slot_end;
    logic               frame_end;
    logic               accept;
    logic               past_blank;
    logic [3:0]         cur_nib;
    logic [DIGITS-1:0]  lz_mask;
    logic               upper_zero;
    logic               show;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (slot_q == SLOT_LAST);
    assign accept    = load_if.load_valid && !pending_full_q;

    // A zero-length blank window would make the comparison trivially true.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign past_blank = 1'b1;
        end else begin : g_blank
            assign past_blank = (cnt_q >= CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            slot_q         <= '0;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            bcd_q          <= 4'd0;
            digit_en_q     <= '0;
            blank_q        <= 1'b1;
            frame_done_q   <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            slot_q         <= slot_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            bcd_q          <= bcd_d;
            digit_en_q     <= digit_en_d;
            blank_q        <= blank_d;
            frame_done_q   <= frame_done_d;
        end
    end

    // Next-state: prescaler, slot pointer and double buffer
    always_comb begin
        cnt_d          = slot_end ? '0 : cnt_q + 1'b1;
        slot_d         = slot_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;

        if (slot_end) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end

        // Transfer only at frame end so a frame never mixes two values.
        if (frame_end && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end

        // Acceptance requires an empty pending slot, so it can never collide
        // with a transfer on the same edge; such a load waits a full frame.
        if (accept) begin
            pending_d      = load_if.load_data;
            pending_full_d = 1'b1;
        end
    end

    // Output next-values computed from the current state, registered above
    always_comb begin
        cur_nib    = active_q[4*slot_q +: 4];
        upper_zero = 1'b1;
        lz_mask    = '0;

        // Walk from the most significant digit down; a digit is a leading zero
        // while it and everything above it are zero. Digit 0 always shows.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (active_q[4*i +: 4] == 4'd0);
            lz_mask[i] = (i != 0) && upper_zero && lz_suppress;
        end

        show         = past_blank && (cur_nib <= 4'd9) && !lz_mask[slot_q];
        bcd_d        = cur_nib;
        digit_en_d   = show ? (DIGITS'(1) << slot_q) : '0;
        blank_d      = !show;
        frame_done_d = frame_end;
    end

    assign load_if.load_ready = !pending_full_q;
    assign bcd_w      = bcd_q[3];
    assign bcd_x      = bcd_q[2];
    assign bcd_y      = bcd_q[1];
    assign bcd_z      = bcd_q[0];
    assign digit_en   = digit_en_q;
    assign blank      = blank_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_bcd_digit_scanner.sv
// tb/tb_bcd_digit_scanner.sv - self-checking bench for bcd_digit_scanner
module tb_bcd_digit_scanner;
    localparam int D = 4;
    localparam int R = 8;
    localparam int B = 2;
    localparam int F = D * R;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         lz_suppress = 1'b0;
    logic         bcd_w, bcd_x, bcd_y, bcd_z;
    logic [D-1:0] digit_en;
    logic         blank;
    logic         frame_done;

    bcd_digit_scanner_if #(.DIGITS(D)) lif();

    bcd_digit_scanner #(
        .DIGITS      (D),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_if    (lif),
        .lz_suppress(lz_suppress),
        .bcd_w      (bcd_w),
        .bcd_x      (bcd_x),
        .bcd_y      (bcd_y),
        .bcd_z      (bcd_z),
        .digit_en   (digit_en),
        .blank      (blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;              // pin cycle index since the last reset edge

    // Reference model: displayed value, buffered value and its full flag
    logic [15:0] m_active = '0;
    logic [15:0] m_pending = '0;
    logic        m_full = 1'b0;
    logic [15:0] prev_active = '0;
    logic        prev_lz = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, n, got, exp);
        end
    endtask

    // Pins in cycle n reflect state of cycle n-1: cnt and slot follow directly
    // from elapsed cycles, the digit from the value held then.
    task automatic check_pins();
        int s, cnt, slot;
        logic [3:0]   nib;
        logic [3:0]   bcd;
        logic         supp, show;
        logic [D-1:0] en;
        bcd = {bcd_w, bcd_x, bcd_y, bcd_z};
        if (n == 0) begin
            check_val("rst_digit_en", 32'(digit_en), 32'h0);
            check_val("rst_blank", 32'(blank), 32'h1);
            check_val("rst_bcd", 32'(bcd), 32'h0);
            check_val("rst_frame_done", 32'(frame_done), 32'h0);
        end else begin
            s    = n - 1;
            cnt  = s % R;
            slot = (s / R) % D;
            nib  = 4'((prev_active >> (4 * slot)) & 16'hF);
            supp = prev_lz && (slot > 0) && ((prev_active >> (4 * slot)) == 16'h0);
            show = (cnt >= B) && (nib <= 4'd9) && !supp;
            en   = show ? D'(1 << slot) : '0;
            check_val("digit_en", 32'(digit_en), 32'(en));
            check_val("blank", 32'(blank), 32'(!show));
            check_val("bcd", 32'(bcd), 32'(nib));
            check_val("frame_done", 32'(frame_done), 32'((s % F) == F - 1));
        end
        check_val("load_ready", 32'(lif.load_ready), 32'(!m_full));
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic lz, output logic acc);
        check_pins();
        lif.load_valid = v;
        lif.load_data  = d;
        lz_suppress    = lz;
        prev_active    = m_active;
        prev_lz        = lz;
        acc = v && !m_full;
        if (((n % F) == F - 1) && m_full) begin
            m_active = m_pending;
            m_full   = 1'b0;
        end
        if (acc) begin
            m_pending = d;
            m_full    = 1'b1;
        end
        @(negedge clk);
        n++;
    endtask

    task automatic idle(input int k, input logic lz);
        logic acc;
        for (int i = 0; i < k; i++) step(1'b0, 16'h0, lz, acc);
    endtask

    task automatic load_value(input logic [15:0] d, input logic lz);
        logic acc;
        int g;
        acc = 1'b0;
        g = 0;
        while (!acc && g < 200) begin
            step(1'b1, d, lz, acc);
            g++;
        end
        if (!acc) check_val("load_timeout", 32'h0, 32'h1);
    endtask

    task automatic do_reset(input int k, input logic v);
        rst            = 1'b1;
        lif.load_valid = v;
        lif.load_data  = 16'h9999;
        repeat (k) @(negedge clk);
        rst       = 1'b0;
        n         = 0;
        m_active  = '0;
        m_pending = '0;
        m_full    = 1'b0;
        prev_active = '0;
    endtask

    initial begin
        logic acc;
        logic got;
        logic lz;
        logic v;
        logic [15:0] d;
        int g;

        lif.load_valid = 1'b0;
        lif.load_data  = '0;
        do_reset(2, 1'b1);

        // Zeros scanned in order with blank windows
        idle(44, 1'b0);

        // Load mid-frame, then hold a second value under backpressure
        step(1'b1, 16'h1234, 1'b0, acc);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(!got, 16'h5678, 1'b0, acc);
            if (acc) got = 1'b1;
        end
        idle(2 * F, 1'b0);

        // Leading-zero suppression on and off
        load_value(16'h0070, 1'b1);
        idle(3 * F, 1'b1);
        idle(F + 4, 1'b0);

        // Invalid nibble does not count as zero
        load_value(16'h0A00, 1'b1);
        idle(3 * F, 1'b1);

        // Reset mid-frame with a load pending
        load_value(16'h1111, 1'b0);
        load_value(16'h2222, 1'b0);
        g = 0;
        while ((((n / R) % D) != 2 || !m_full) && g < 100) begin
            step(1'b0, 16'h0, 1'b0, acc);
            g++;
        end
        do_reset(1, 1'b1);
        idle(2 * F, 1'b0);

        // Randomized traffic
        lz = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            v = ($urandom_range(0, 5) == 0);
            for (int j = 0; j < 4; j++)
                d[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) lz = ~lz;
            if ($urandom_range(0, 599) == 0) do_reset(1 + $urandom_range(0, 1), v);
            else step(v, d, lz, acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_digit_scanner.md
# bcd_digit_scanner

Time-multiplexed scan controller that sits directly upstream of the BCD-to-7-segment decoder. It holds a multi-digit BCD value and drives one nibble at a time onto the decoder inputs (w = MSB … z = LSB), together with a one-hot digit enable. It accepts new values through a valid/ready handshake, double-buffers them so a frame never tears, inserts anti-ghosting blank cycles and optionally suppresses leading zeros.

## Interface

Parameters:
- DIGITS, 4, number of BCD digits scanned; digit 0 is least significant. Legal range ≥1.
- REFRESH_DIV, 1000, clock cycles per digit slot. Legal range ≥2.
- BLANK_CYCLES, 2, blank cycles at the start of each slot. Legal range 0 ≤ BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  block can accept a load.
- load_data  in  4*DIGITS  BCD value; nibble i at bits [4i+3:4i].
- lz_suppress  in  1  enables leading-zero blanking; sampled every cycle.
- bcd_w, bcd_x, bcd_y, bcd_z  out  1 each  current nibble to the decoder; bcd_w is MSB.
- digit_en  out  DIGITS  one-hot, active-high digit enable; all zero while blanked.
- blank  out  1  high when digit_en is all zero.
- frame_done  out  1  one-cycle pulse on the last cycle of slot DIGITS-1.

## Operation

- State: prescaler cnt (0..REFRESH_DIV-1), slot index (0..DIGITS-1), active register, pending register with a full flag.
- cnt increments every cycle. At REFRESH_DIV-1 it wraps to 0 and the slot advances. Slot DIGITS-1 wraps to slot 0.
- Handshake: load_ready = ~pending_full. A load is accepted when load_valid & load_ready at a rising edge. The data goes into pending and sets pending_full. load_data is not held for the caller.
- Frame end is the edge that ends slot DIGITS-1 (cnt = REFRESH_DIV-1). At frame end, pending_full=1 copies pending to active and clears pending_full.
- A load accepted on the frame-end edge itself stays in pending until the next frame end. There is no bypass to active.
- Only the active register is displayed. New data first appears in slot 0 of the frame after the transfer.
- bcd_w..z always carry active nibble[slot], including during blank cycles.
- A slot is shown (digit_en[slot]=1) only if all of the following hold:
  - cnt ≥ BLANK_CYCLES;
  - the nibble is ≤ 9;
  - the slot is not leading-zero suppressed.
- Otherwise digit_en is all zero and blank=1.
- Leading-zero suppression: when lz_suppress=1, digit i>0 is suppressed if nibble i and every higher nibble equal 0. Digit 0 is never suppressed.
- Out-of-range nibbles (10–15) blank their own slot only. They do not count as zero for leading-zero suppression.

## Timing

- All outputs are registered. Each output reflects the cnt and slot values held in the previous cycle, so there is one cycle of latency from state to pins. The pattern relative to the pins is fixed, as below.
- Reset values, seen on the first cycle after a rst edge:
  - cnt=0, slot=0, active=0, pending_full=0;
  - load_ready=1, digit_en=0, blank=1, bcd_w..z=0, frame_done=0.
- rst high on any edge, including mid-frame or mid-handshake, fully re-initialises the block. Any pending and active data is discarded. A load_valid present on that edge is not accepted.
- Per slot on the pins: blank=1 for BLANK_CYCLES cycles, then digit_en one-hot for REFRESH_DIV-BLANK_CYCLES cycles (unless blanked by a rule above).
- One frame lasts DIGITS*REFRESH_DIV cycles.
- frame_done is high for exactly one cycle per frame, coincident on the pins with the last cycle of slot DIGITS-1.
- load_ready goes low the cycle after an acceptance. It returns high the cycle after the frame-end transfer.
- With BLANK_CYCLES=0, digit_en is never all zero because of blanking. blank then reflects only the digit-validity and suppression rules.

## Test plan

All scenarios use DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.

- **Reset.** Assert rst for 2 cycles, then release.
  - Required: digit_en=0000, blank=1, load_ready=1, bcd=0 immediately after reset.
  - Active=0 and lz_suppress=0, so digits show 0 in order 0001, 0010, 0100, 1000.
  - Each slot has 2 blank cycles then 6 enabled cycles. frame_done pulses every 32 cycles.
- **Load and display.** Load 0x1234 mid-frame.
  - load_ready drops for the rest of the frame and rises one cycle after frame end.
  - In the next frame: slot 0 shows bcd=4 with digit_en=0001; slots 1, 2, 3 show 3, 2, 1.
- **Backpressure.** Assert load_valid with 0x5678 every cycle right after 0x1234 is accepted.
  - 0x5678 is accepted only on the cycle load_ready is high after the transfer.
  - 0x5678 is displayed starting one frame later.
- **Leading-zero suppression.** Load 0x0070 with lz_suppress=1.
  - Slots 3 and 2 have digit_en=0000.
  - Slot 1 shows 7 and slot 0 shows 0.
  - With lz_suppress=0, all four slots are enabled.
- **Invalid nibble.** Load 0x0A00 with lz_suppress=1.
  - Slot 3 is suppressed; slot 2 is blanked as invalid while bcd=1010 is still driven.
  - Slots 1 and 0 show 0.
- **Reset mid-frame.** Start in slot 2 with a load pending; assert rst for 1 cycle.
  - Required: all reset values restored and the pending load lost.
  - The scan restarts at slot 0, cnt 0, showing 0000.
